pending_encoder32x5: RTL and testbench

//  Inverse of the 5x32 one-hot decoder: collects one-hot/multi-hot event bits (e.g. interrupt or

---
 rtl/pending_encoder32x5_pkg.sv | 13 +
 rtl/pending_encoder32x5_if.sv | 12 +
 rtl/pending_encoder32x5_prio_encoder.sv | 29 ++
 rtl/pending_encoder32x5.sv | 101 ++++++++++
 tb/tb_pending_encoder32x5.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pending_encoder32x5_pkg.sv
// Shared definitions for the pending-event encoder: index/vector widths and FSM state encoding.
// Build option ROUND_ROBIN_EN (see pending_encoder32x5.sv) does not affect this package.
package pending_encoder32x5_pkg;

    localparam int IDX_W = 5;
    localparam int VEC_W = 1 << IDX_W;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/pending_encoder32x5_if.sv
// Valid/ready channel carrying one encoded event index per transfer.
interface pending_encoder32x5_if;
    import pending_encoder32x5_pkg::*;

    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;

    modport master (output out_valid, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_idx, output out_ready);

endinterface

// File: rtl/pending_encoder32x5_prio_encoder.sv
// Lowest-set-bit finder over VEC_W bits, searching upward from a rotate start position and wrapping.
module pending_encoder32x5_prio_encoder
    import pending_encoder32x5_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*VEC_W-1:0] dbl;
    logic [VEC_W-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotating right by start puts bit 'start' at position 0, so the lowest
    // set bit of rot is the first hit at or above start (with wrap).
    always_comb begin
        dbl = {vec, vec} >> start;
        rot = dbl[VEC_W-1:0];
        off = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign idx = off + start;
    assign any = |vec;

endmodule

// File: rtl/pending_encoder32x5.sv
// Sticky pending-event collector emitting one binary index per valid/ready transfer.
// Define ROUND_ROBIN_EN for round-robin selection; default build is fixed lowest-index priority.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | nothing presented; load an index when en and pending
// ST_PRESENT | out_idx valid and held until the consumer accepts it
module pending_encoder32x5
    import pending_encoder32x5_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [VEC_W-1:0]       set,
    pending_encoder32x5_if.master  bus,
    output logic [VEC_W-1:0]       pending,
    output logic                   empty
);

    state_t           state, state_nx;
    logic             load;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] out_idx_q;
    logic [VEC_W-1:0] sel_clear;

    pending_encoder32x5_prio_encoder u_prio (
        .vec   (pending),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_granted;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_granted <= IDX_W'(VEC_W - 1);
        end else if (load) begin
            last_granted <= sel_idx;
        end
    end

    assign start = last_granted + IDX_W'(1);
`else
    assign start = '0;
`endif

    // A new index is taken from an idle slot or from one freed by a transfer this cycle.
    assign load = en && sel_any &&
                  ((state == ST_IDLE) || ((state == ST_PRESENT) && bus.out_ready));

    assign sel_clear = load ? (VEC_W'(1) << sel_idx) : '0;

    // set is OR'd after the clear so a same-cycle event on the selected bit survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~sel_clear) | set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx_q <= '0;
        end else if (load) begin
            out_idx_q <= sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (load) state_nx = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.out_ready) state_nx = load ? ST_PRESENT : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == ST_PRESENT);
        bus.out_idx   = out_idx_q;
        empty         = (pending == '0) && (state != ST_PRESENT);
    end

endmodule

// File: tb/tb_pending_encoder32x5.sv
// Directed-vector bench for pending_encoder32x5; expected order follows ROUND_ROBIN_EN when defined.
module tb_pending_encoder32x5;
    import pending_encoder32x5_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic [VEC_W-1:0] set;
    logic [VEC_W-1:0] pending;
    logic             empty;

    int n_chk;
    int n_fail;

    pending_encoder32x5_if bus();

    pending_encoder32x5 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .set     (set),
        .bus     (bus),
        .pending (pending),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        en     = 1'b1;
        set    = '0;
        bus.out_ready = 1'b0;

        // reset dominates a full set vector
        set = 32'hFFFF_FFFF;
        step();
        step();
        chk("rst_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_idx",     32'(bus.out_idx),   32'd0);
        chk("rst_pending", pending,            32'd0);
        chk("rst_empty",   32'(empty),         32'd1);
        rst = 1'b0;
        set = '0;

        // two events, delivered in order with 2-cycle latency
        bus.out_ready = 1'b1;
        set = 32'h0000_0024;
        step();
        set = '0;
        chk("t2_pend0",  pending,            32'h24);
        chk("t2_valid0", 32'(bus.out_valid), 32'd0);
        step();
        chk("t2_valid1", 32'(bus.out_valid), 32'd1);
        chk("t2_idx1",   32'(bus.out_idx),   32'd2);
        chk("t2_pend1",  pending,            32'h20);
        step();
        chk("t2_valid2", 32'(bus.out_valid), 32'd1);
        chk("t2_idx2",   32'(bus.out_idx),   32'd5);
        step();
        chk("t2_empty",  32'(empty),         32'd1);
        chk("t2_valid3", 32'(bus.out_valid), 32'd0);

        // stall holds the index, then release
        do_reset();
        bus.out_ready = 1'b0;
        set = 32'h8000_0001;
        step();
        set = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_idx",   32'(bus.out_idx),   32'd0);
            chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_hold_pend",  pending,            32'h8000_0000);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("t3_idx31",  32'(bus.out_idx),   32'd31);
        chk("t3_valid",  32'(bus.out_valid), 32'd1);
        chk("t3_pend",   pending,            32'd0);
        step();
        chk("t3_empty",  32'(empty),         32'd1);

        // re-set of the presented bit is a new event
        do_reset();
        bus.out_ready = 1'b0;
        set = 32'h8;
        step();
        set = '0;
        step();
        chk("t4_idx3",   32'(bus.out_idx),   32'd3);
        bus.out_ready = 1'b1;
        set = 32'h8;
        step();
        set = '0;
        chk("t4_pend",   pending,            32'h8);
        step();
        chk("t4_valid",  32'(bus.out_valid), 32'd1);
        chk("t4_again",  32'(bus.out_idx),   32'd3);
        step();
        chk("t4_empty",  32'(empty),         32'd1);

        // en gates selection only
        do_reset();
        en  = 1'b0;
        set = 32'h10;
        step();
        set = '0;
        step();
        chk("t5_valid0", 32'(bus.out_valid), 32'd0);
        chk("t5_pend",   pending,            32'h10);
        chk("t5_nempty", 32'(empty),         32'd0);
        en = 1'b1;
        step();
        chk("t5_valid1", 32'(bus.out_valid), 32'd1);
        chk("t5_idx4",   32'(bus.out_idx),   32'd4);
        step();

        // selection order after granting index 2
        do_reset();
        bus.out_ready = 1'b1;
        set = 32'h4;
        step();
        set = '0;
        step();
        chk("t6_idx2",   32'(bus.out_idx),   32'd2);
        set = 32'h22;
        step();
        set = '0;
        chk("t6_pend",   pending,            32'h22);
        step();
`ifdef ROUND_ROBIN_EN
        chk("t6_first",  32'(bus.out_idx),   32'd5);
        step();
        chk("t6_second", 32'(bus.out_idx),   32'd1);
`else
        chk("t6_first",  32'(bus.out_idx),   32'd1);
        step();
        chk("t6_second", 32'(bus.out_idx),   32'd5);
`endif
        chk("t6_valid",  32'(bus.out_valid), 32'd1);
        step();
        chk("t6_empty",  32'(empty),         32'd1);

        // reset while presenting
        bus.out_ready = 1'b0;
        set = 32'h1;
        step();
        set = 32'h6;
        step();
        set = '0;
        chk("t7_pres",   32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_valid",  32'(bus.out_valid), 32'd0);
        chk("t7_pend",   pending,            32'd0);
        chk("t7_empty",  32'(empty),         32'd1);

        // all 32 bits drain back-to-back in index order
        do_reset();
        bus.out_ready = 1'b1;
        set = 32'hFFFF_FFFF;
        step();
        set = '0;
        step();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.out_valid) break;
            chk("t8_idx", 32'(bus.out_idx), 32'(seen));
            seen++;
            step();
        end
        chk("t8_count",  32'(seen),  32'd32);
        chk("t8_empty",  32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
